// File: rtl/multi_ch_reg_config_pkg.sv
// multi_ch_reg_config_pkg: register map and shared widths for the channel config bank
package multi_ch_reg_config_pkg;
  localparam logic [7:0] ADDR_FREQ0     = 8'h03;
  localparam logic [7:0] ADDR_COMMIT    = 8'h09;
  localparam logic [7:0] ADDR_ON_OFF    = 8'h2D;
  localparam logic [7:0] ADDR_SYNC_MODE = 8'h2E;
  localparam logic [7:0] ADDR_ATTEN     = 8'h31;
  localparam logic [7:0] ADDR_PROT_CLR  = 8'h5A;
  localparam int ATTEN_W = 4;
endpackage

// File: rtl/multi_ch_reg_config_if.sv
// multi_ch_reg_config_if: byte-wide host config write bus shared by all channels
interface multi_ch_reg_config_if #(
  parameter int CH_SEL_W = 1
) ();
  logic                CH_CONFIG_WE;
  logic [CH_SEL_W-1:0] CH_CONFIG_CH;
  logic [7:0]          CH_CONFIG_ADDR;
  logic [7:0]          CH_CONFIG_DATA;
  modport master (output CH_CONFIG_WE, CH_CONFIG_CH, CH_CONFIG_ADDR, CH_CONFIG_DATA);
  modport slave (input CH_CONFIG_WE, CH_CONFIG_CH, CH_CONFIG_ADDR, CH_CONFIG_DATA);
endinterface

// File: rtl/multi_ch_reg_config_ch_load_protect.sv
// ch_load_protect: synchronised, debounced load-fault latch with software clear flag
module ch_load_protect #(
  parameter int PROT_DELAY = 25000
) (
  input  logic CLK_LOW,
  input  logic RST_N,
  input  logic load_in,
  input  logic clr_wr,
  output logic state,
  output logic prot_event
);
  logic sync1, s, s_d, clr, fall, qual;
  logic [15:0] cnt;
  assign fall = s_d & ~s;
  assign qual = cnt == 16'(PROT_DELAY);
  // synchronise, count the low run, and latch a qualified fault until cleared
  always_ff @(posedge CLK_LOW or negedge RST_N)
    if (!RST_N) begin
      sync1      <= 1'b1;
      s          <= 1'b1;
      s_d        <= 1'b1;
      clr        <= 1'b1;
      cnt        <= '0;
      state      <= 1'b0;
      prot_event <= 1'b0;
    end else begin
      sync1      <= load_in;
      s          <= sync1;
      s_d        <= s;
      cnt        <= s ? '0 : qual ? cnt : cnt + 16'd1;
      clr        <= fall ? 1'b0 : clr | clr_wr;
      state      <= qual | (state & ~clr);
      prot_event <= qual & ~state;
    end
endmodule

// File: rtl/multi_ch_reg_config.sv
// multi_ch_reg_config: per-channel shadow/active frequency bank with commit control and load protection
module multi_ch_reg_config
  import multi_ch_reg_config_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int FREQ_W     = 48,
  parameter int PROT_DELAY = 25000
) (
  input  logic                        CLK_LOW,
  input  logic                        RST_N,
  multi_ch_reg_config_if.slave        cfg,
  input  logic [NUM_CH-1:0]           CH_LOAD_PROTECT,
  output logic [NUM_CH*FREQ_W-1:0]    STAND_FREQ_INC,
  output logic [NUM_CH-1:0]           FREQ_UPDATE,
  output logic [NUM_CH-1:0]           CH_ON_OFF,
  output logic [NUM_CH*ATTEN_W-1:0]   CH_CNT_ATTEN,
  output logic [NUM_CH-1:0]           CH_LOAD_PROTECT_STATE,
  output logic [NUM_CH-1:0]           PROT_EVENT
);
  localparam int NB = FREQ_W / 8;
  localparam logic [7:0] ADDR_LAST = ADDR_FREQ0 + 8'(NB - 1);
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic sel, commit, pend, upd, on_reg, on_off, sync_mode, state;
    logic [FREQ_W-1:0] shadow, active;
    logic [ATTEN_W-1:0] atten;
    assign sel    = cfg.CH_CONFIG_WE && 32'(cfg.CH_CONFIG_CH) == k;
    assign commit = (sel && cfg.CH_CONFIG_ADDR == ADDR_LAST && !sync_mode) ||
                    (cfg.CH_CONFIG_WE && cfg.CH_CONFIG_ADDR == ADDR_COMMIT && cfg.CH_CONFIG_DATA[k]);
    assign STAND_FREQ_INC[k*FREQ_W +: FREQ_W]  = active;
    assign CH_CNT_ATTEN[k*ATTEN_W +: ATTEN_W] = atten;
    assign FREQ_UPDATE[k]           = upd;
    assign CH_ON_OFF[k]             = on_off;
    assign CH_LOAD_PROTECT_STATE[k] = state;
    // register writes, commit one cycle behind its trigger, gated output enable
    always_ff @(posedge CLK_LOW or negedge RST_N)
      if (!RST_N) begin
        shadow    <= '0;
        active    <= '0;
        pend      <= 1'b0;
        upd       <= 1'b0;
        on_reg    <= 1'b0;
        on_off    <= 1'b0;
        sync_mode <= 1'b0;
        atten     <= '0;
      end else begin
        for (int b = 0; b < NB; b++)
          if (sel && cfg.CH_CONFIG_ADDR == ADDR_FREQ0 + 8'(b)) shadow[b*8 +: 8] <= cfg.CH_CONFIG_DATA;
        if (sel && cfg.CH_CONFIG_ADDR == ADDR_ON_OFF) on_reg <= cfg.CH_CONFIG_DATA[0];
        if (sel && cfg.CH_CONFIG_ADDR == ADDR_SYNC_MODE) sync_mode <= cfg.CH_CONFIG_DATA[0];
        if (sel && cfg.CH_CONFIG_ADDR == ADDR_ATTEN) atten <= cfg.CH_CONFIG_DATA[ATTEN_W-1:0];
        pend   <= commit;
        upd    <= pend;
        if (pend) active <= shadow;
        on_off <= on_reg & ~state;
      end
    ch_load_protect #(.PROT_DELAY(PROT_DELAY)) u_prot (
      .CLK_LOW    (CLK_LOW),
      .RST_N      (RST_N),
      .load_in    (CH_LOAD_PROTECT[k]),
      .clr_wr     (sel && cfg.CH_CONFIG_ADDR == ADDR_PROT_CLR && cfg.CH_CONFIG_DATA[0]),
      .state      (state),
      .prot_event (PROT_EVENT[k])
    );
  end
endmodule
